// File: rtl/ras_ctrl.sv
// Return-address-stack controller: one control-transfer record per cycle in,
// registered next-PC out, with checkpoint export and redirect restore.
module ras_ctrl #(
    parameter int DEPTH = 9,
    parameter int AW    = 32
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid_1,
    output logic          o_ready_1,
    input  logic [2:0]    i_type_3,
    input  logic [AW-1:0] i_jaddr_32,
    input  logic [AW-1:0] i_retAddr_32,
    input  logic          i_redirect_1,
    input  logic [7:0]    i_restore_8,
    output logic          o_valid_1,
    output logic [AW-1:0] o_nextPc_32,
    output logic [7:0]    o_ckpt_8,
    output logic          o_underflow_1,
    output logic          o_overflow_1,
    output logic [3:0]    o_count_4
);

    typedef enum logic {RUN, RECOVER} state_t;

    localparam logic [3:0] DEPTH_4 = 4'(DEPTH);
    localparam logic [3:0] TOP_MAX = 4'(DEPTH - 1);

    localparam logic [2:0] T_CALL = 3'd4;
    localparam logic [2:0] T_RET  = 3'd5;

    state_t        state;
    logic [3:0]    top;
    logic [3:0]    count;
    logic [AW-1:0] mem [DEPTH];

    logic       acc;
    logic [3:0] top_inc;
    logic [3:0] top_dec;
    logic [3:0] rst_top;
    logic [3:0] rst_count;

    assign o_ready_1 = (state == RUN);
    assign o_count_4 = count;
    assign acc       = i_valid_1 & o_ready_1 & ~i_redirect_1;

    assign top_inc = (top == TOP_MAX) ? 4'd0 : top + 4'd1;
    assign top_dec = (top == 4'd0) ? TOP_MAX : top - 4'd1;

    // Corrupt checkpoints are clamped so the pointers always stay in range.
    assign rst_top   = (i_restore_8[3:0] >= DEPTH_4) ? 4'd0 : i_restore_8[3:0];
    assign rst_count = (i_restore_8[7:4] > DEPTH_4) ? DEPTH_4 : i_restore_8[7:4];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= RUN;
            top           <= TOP_MAX;
            count         <= 4'd0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            o_valid_1     <= 1'b0;
            o_nextPc_32   <= '0;
            o_ckpt_8      <= 8'd0;
            o_underflow_1 <= 1'b0;
            o_overflow_1  <= 1'b0;
        end else begin
            o_valid_1     <= 1'b0;
            o_underflow_1 <= 1'b0;
            o_overflow_1  <= 1'b0;
            if (i_redirect_1) begin
                top   <= rst_top;
                count <= rst_count;
                state <= RECOVER;
            end else begin
                state <= RUN;
                if (acc) begin
                    o_valid_1 <= 1'b1;
                    o_ckpt_8  <= {count, top};
                    case (i_type_3)
                        T_CALL: begin
                            top          <= top_inc;
                            mem[top_inc] <= i_retAddr_32;
                            o_nextPc_32  <= i_jaddr_32;
                            if (count == DEPTH_4) o_overflow_1 <= 1'b1;
                            else                  count <= count + 4'd1;
                        end
                        T_RET: begin
                            if (count != 4'd0) begin
                                o_nextPc_32 <= mem[top];
                                top         <= top_dec;
                                count       <= count - 4'd1;
                            end else begin
                                o_nextPc_32   <= i_jaddr_32;
                                o_underflow_1 <= 1'b1;
                            end
                        end
                        default: o_nextPc_32 <= i_jaddr_32;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl: a vector table for back-to-back records plus
// hand sequences for reset, redirect/restore and checkpoint clamping.
module tb_ras_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic        ready;
    logic [2:0]  typ = 3'd0;
    logic [31:0] jaddr = '0;
    logic [31:0] ret_addr = '0;
    logic        redirect = 1'b0;
    logic [7:0]  restore = 8'd0;
    logic        out_valid;
    logic [31:0] next_pc;
    logic [7:0]  ckpt;
    logic        underflow;
    logic        overflow;
    logic [3:0]  count;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ras_ctrl #(.DEPTH(9), .AW(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid_1(valid), .o_ready_1(ready),
        .i_type_3(typ), .i_jaddr_32(jaddr), .i_retAddr_32(ret_addr),
        .i_redirect_1(redirect), .i_restore_8(restore),
        .o_valid_1(out_valid), .o_nextPc_32(next_pc), .o_ckpt_8(ckpt),
        .o_underflow_1(underflow), .o_overflow_1(overflow), .o_count_4(count)
    );

    typedef struct {
        logic [2:0]  typ;
        logic [31:0] jaddr;
        logic [31:0] ret_addr;
        logic [31:0] pc;
        logic [7:0]  ckpt;
        logic        under;
        logic        over;
        logic [3:0]  cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [2:0] t, input logic [31:0] j, input logic [31:0] r,
                       input logic [31:0] pc, input logic [7:0] ck,
                       input logic u, input logic o, input logic [3:0] c);
        vec_t v;
        v.typ = t; v.jaddr = j; v.ret_addr = r; v.pc = pc; v.ckpt = ck;
        v.under = u; v.over = o; v.cnt = c;
        vecs.push_back(v);
    endtask

    // Offer one record at a negedge; outputs are checked at the following negedge.
    task automatic drive(input logic [2:0] t, input logic [31:0] j, input logic [31:0] r);
        valid = 1'b1; typ = t; jaddr = j; ret_addr = r;
    endtask

    task automatic idle();
        valid = 1'b0; typ = 3'd0; jaddr = '0; ret_addr = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        redirect = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_rec(input string name, input logic [31:0] pc, input logic [7:0] ck,
                           input logic u, input logic o, input logic [3:0] c);
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".pc"}, next_pc, pc);
        chk({name, ".ckpt"}, 32'(ckpt), 32'(ck));
        chk({name, ".under"}, 32'(underflow), 32'(u));
        chk({name, ".over"}, 32'(overflow), 32'(o));
        chk({name, ".count"}, 32'(count), 32'(c));
    endtask

    initial begin
        // CALL then RET from reset (count 0, top 8)
        add(3'd4, 32'h2000, 32'h1004, 32'h2000, 8'h08, 0, 0, 4'd1);
        add(3'd5, 32'h3000, 32'h0,    32'h1004, 8'h10, 0, 0, 4'd0);
        // passthrough types, stack back at count 0 top 8
        add(3'd0, 32'hDEAD_BEE0, 32'h0, 32'hDEAD_BEE0, 8'h08, 0, 0, 4'd0);
        add(3'd1, 32'hDEAD_BEE0, 32'h0, 32'hDEAD_BEE0, 8'h08, 0, 0, 4'd0);
        add(3'd2, 32'hDEAD_BEE0, 32'h0, 32'hDEAD_BEE0, 8'h08, 0, 0, 4'd0);
        add(3'd3, 32'hDEAD_BEE0, 32'h0, 32'hDEAD_BEE0, 8'h08, 0, 0, 4'd0);
        add(3'd7, 32'hDEAD_BEE0, 32'h0, 32'hDEAD_BEE0, 8'h08, 0, 0, 4'd0);
        add(3'd6, 32'hDEAD_BEE0, 32'h0, 32'hDEAD_BEE0, 8'h08, 0, 0, 4'd0);
        // ten CALLs: 10th overflows and overwrites mem[0] (was 0x100)
        add(3'd4, 32'h4001, 32'h100, 32'h4001, 8'h08, 0, 0, 4'd1);
        add(3'd4, 32'h4002, 32'h200, 32'h4002, 8'h10, 0, 0, 4'd2);
        add(3'd4, 32'h4003, 32'h300, 32'h4003, 8'h21, 0, 0, 4'd3);
        add(3'd4, 32'h4004, 32'h400, 32'h4004, 8'h32, 0, 0, 4'd4);
        add(3'd4, 32'h4005, 32'h500, 32'h4005, 8'h43, 0, 0, 4'd5);
        add(3'd4, 32'h4006, 32'h600, 32'h4006, 8'h54, 0, 0, 4'd6);
        add(3'd4, 32'h4007, 32'h700, 32'h4007, 8'h65, 0, 0, 4'd7);
        add(3'd4, 32'h4008, 32'h800, 32'h4008, 8'h76, 0, 0, 4'd8);
        add(3'd4, 32'h4009, 32'h900, 32'h4009, 8'h87, 0, 0, 4'd9);
        add(3'd4, 32'h400A, 32'hA00, 32'h400A, 8'h98, 0, 1, 4'd9);
        // nine RETs pop 0xA00 down to 0x200, wrapping top 0 -> 8
        add(3'd5, 32'h5000, 32'h0, 32'hA00, 8'h90, 0, 0, 4'd8);
        add(3'd5, 32'h5000, 32'h0, 32'h900, 8'h88, 0, 0, 4'd7);
        add(3'd5, 32'h5000, 32'h0, 32'h800, 8'h77, 0, 0, 4'd6);
        add(3'd5, 32'h5000, 32'h0, 32'h700, 8'h66, 0, 0, 4'd5);
        add(3'd5, 32'h5000, 32'h0, 32'h600, 8'h55, 0, 0, 4'd4);
        add(3'd5, 32'h5000, 32'h0, 32'h500, 8'h44, 0, 0, 4'd3);
        add(3'd5, 32'h5000, 32'h0, 32'h400, 8'h33, 0, 0, 4'd2);
        add(3'd5, 32'h5000, 32'h0, 32'h300, 8'h22, 0, 0, 4'd1);
        add(3'd5, 32'h5000, 32'h0, 32'h200, 8'h11, 0, 0, 4'd0);
        add(3'd5, 32'h5555, 32'h0, 32'h5555, 8'h00, 1, 0, 4'd0);

        // reset, then a record in flight when reset hits again
        do_reset();
        drive(3'd4, 32'h7000, 32'h7004);
        @(negedge clk);
        idle();
        chk("inflight.valid", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.valid", 32'(out_valid), 32'd0);
        chk("rst.pc", next_pc, 32'd0);
        chk("rst.ckpt", 32'(ckpt), 32'd0);
        chk("rst.flags", {30'd0, underflow, overflow}, 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.ready", 32'(ready), 32'd1);
        chk("rst.valid_idle", 32'(out_valid), 32'd0);

        // table-driven back-to-back records
        foreach (vecs[i]) begin
            drive(vecs[i].typ, vecs[i].jaddr, vecs[i].ret_addr);
            @(negedge clk);
            chk_rec($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ckpt,
                    vecs[i].under, vecs[i].over, vecs[i].cnt);
        end
        idle();
        @(negedge clk);
        chk("after_table.valid", 32'(out_valid), 32'd0);

        // clamp: state is count 0, top 0, mem[0] = 0xA00; two redirects back to back
        drive(3'd5, 32'h6000, 32'h0);
        redirect = 1'b1; restore = 8'hFF;
        @(negedge clk);
        chk("clamp.drop", 32'(out_valid), 32'd0);
        chk("clamp.ready1", 32'(ready), 32'd0);
        chk("clamp.count", 32'(count), 32'd9);
        @(negedge clk);
        chk("clamp.ready2", 32'(ready), 32'd0);
        redirect = 1'b0; restore = 8'h00;
        idle();
        @(negedge clk);
        chk("clamp.ready3", 32'(ready), 32'd1);
        chk("clamp.novalid", 32'(out_valid), 32'd0);
        drive(3'd5, 32'h6000, 32'h0);
        @(negedge clk);
        chk_rec("clamp.ret", 32'hA00, 8'h90, 0, 0, 4'd8);
        drive(3'd0, 32'h6100, 32'h0);
        @(negedge clk);
        chk_rec("clamp.top", 32'h6100, 8'h88, 0, 0, 4'd8);
        idle();

        // redirect restore: rewind to the checkpoint taken after the first push
        do_reset();
        drive(3'd4, 32'h8000, 32'h111); @(negedge clk);
        chk_rec("rd.call1", 32'h8000, 8'h08, 0, 0, 4'd1);
        drive(3'd4, 32'h8001, 32'h222); @(negedge clk);
        chk_rec("rd.call2", 32'h8001, 8'h10, 0, 0, 4'd2);
        drive(3'd4, 32'h8002, 32'h333); @(negedge clk);
        drive(3'd4, 32'h8003, 32'h444); @(negedge clk);
        chk_rec("rd.call4", 32'h8003, 8'h32, 0, 0, 4'd4);
        drive(3'd5, 32'h9000, 32'h0);
        redirect = 1'b1; restore = 8'h10;
        @(negedge clk);
        chk("rd.drop", 32'(out_valid), 32'd0);
        chk("rd.bubble", 32'(ready), 32'd0);
        chk("rd.count", 32'(count), 32'd1);
        redirect = 1'b0; restore = 8'h00;
        @(negedge clk);
        chk("rd.ignored", 32'(out_valid), 32'd0);
        chk("rd.ready", 32'(ready), 32'd1);
        @(negedge clk);
        chk_rec("rd.ret", 32'h111, 8'h10, 0, 0, 4'd0);
        idle();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Return-address-stack controller for the fetch redirect path: it consumes one decoded control-transfer record per cycle and produces the registered next PC. CALL records push a return address; RET records pop the predicted target from a circular 9-entry stack; all other types pass the jump address through. It exports a stack checkpoint with every result and restores from one on a back-end redirect, sequencing a one-cycle recovery bubble.

## Interface
- DEPTH, 9, stack entries; 2..15.
- AW, 32, address width.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid_1  in  1  record offered this cycle.
- o_ready_1  out  1  controller can accept a record.
- i_type_3  in  3  0 NORMAL, 1 B, 2 J, 3 JALR, 4 CALL, 5 RET; 6 and 7 are treated as NORMAL.
- i_jaddr_32  in  AW  decoded target address.
- i_retAddr_32  in  AW  return address to push on CALL.
- i_redirect_1  in  1  back-end mispredict; restore the checkpoint.
- i_restore_8  in  8  checkpoint {count[7:4], top[3:0]} to restore.
- o_valid_1  out  1  result pulse.
- o_nextPc_32  out  AW  predicted next PC.
- o_ckpt_8  out  8  pre-update {count, top} of the accepted record.
- o_underflow_1  out  1  RET accepted with an empty stack.
- o_overflow_1  out  1  CALL accepted with a full stack; oldest entry overwritten.
- o_count_4  out  4  live entries, 0..DEPTH.

## Operation
- State: `top` (0..DEPTH-1, index of the newest entry), `count` (0..DEPTH), and entry array `mem[DEPTH]` of AW bits. The FSM has two states, RUN and RECOVER.
- Accept condition: `acc = i_valid_1 & o_ready_1 & ~i_redirect_1`.
- `o_ready_1` is 1 only in RUN.
- On `acc`, by type:
  - CALL: `top' = (top+1) mod DEPTH`, `mem[top'] = i_retAddr_32`, `count' = min(count+1, DEPTH)`. Output `o_nextPc = i_jaddr_32`. If `count == DEPTH`, pulse `o_overflow_1`.
  - RET with `count > 0`: output `mem[top]`, then `top' = (top+DEPTH-1) mod DEPTH`, `count' = count-1`.
  - RET with `count == 0`: output `i_jaddr_32` and pulse `o_underflow_1`; stack unchanged.
  - All other types: output `i_jaddr_32`; stack unchanged.
- `o_ckpt_8` carries `{count, top}` as they were before this record's update.
- Redirect (in any state):
  - `top = i_restore_8[3:0]` and `count = i_restore_8[7:4]`; `mem` is untouched.
  - Any same-cycle request is dropped, with no `o_valid_1` for it.
  - Next state is RECOVER.
  - Restore values out of range (`top >= DEPTH` or `count > DEPTH`) are clamped: `top` to 0, `count` to DEPTH.
- RECOVER always goes to RUN on the next cycle. A further redirect while in RECOVER restores again and stays in RECOVER.
- Wrap-around: top increments from DEPTH-1 to 0 and decrements from 0 to DEPTH-1.

## Timing
- Latency is 1: `o_valid_1`, `o_nextPc_32`, `o_ckpt_8`, `o_underflow_1` and `o_overflow_1` are registered and valid the cycle after `acc`. The flags are single-cycle pulses.
- There is no downstream backpressure.
- Back-to-back records are accepted every cycle. A RET directly after a CALL sees the pushed value, because the stack updates at the accept edge.
- Redirect costs exactly one bubble: the redirect edge is followed by one RECOVER cycle with `o_ready_1 = 0`.
- `o_count_4` reflects the registered `count`.
- Reset, asynchronous on falling `i_rst_n`:
  - State is RUN; `top = DEPTH-1`, `count = 0`; `mem` is all 0.
  - All outputs are 0 except `o_ready_1`, which is 1 once `i_rst_n` is high.
  - Reset asserted mid-stream discards any in-flight result.

## Test plan
- **Reset:** assert `i_rst_n` low mid-stream, then release.
  - All outputs 0.
  - `o_ready_1 = 1`.
  - `o_count_4 = 0`.
- **CALL then RET:** CALL with `retAddr = 0x1004`, `jaddr = 0x2000`, then a RET.
  - Cycle +1: `nextPc = 0x2000`, `ckpt = 0x08`.
  - Cycle +2: `nextPc = 0x1004`, `count = 0`.
- **Overflow:** 10 CALLs with `retAddr = 0x100*k`, k = 1..10.
  - 10th CALL: `o_overflow_1` pulses.
  - `count` holds at 9.
  - 9 RETs return 0xA00 down to 0x200.
  - A 10th RET pulses `o_underflow_1` and returns its `jaddr`.
- **Redirect and restore:** push 3 entries (checkpoint after the first is `0x10`), push more, then `i_redirect_1` with `i_restore_8 = 0x10` together with a valid RET.
  - No output for the dropped RET.
  - `o_ready_1 = 0` for one cycle.
  - The next RET returns the first pushed value.
- **Passthrough:** NORMAL, B, J, JALR, type 7, each with `jaddr = 0xDEAD_BEE0`.
  - `nextPc = 0xDEAD_BEE0` for each.
  - `count` unchanged.
  - No flags.
- **Clamp:** redirect with `i_restore_8 = 0xFF`.
  - `count = 9`, `top = 0`.
  - The following RET pops `mem[0]`, and `top` becomes 8.
